demo_axil_regs: RTL and testbench
=================================

DEMO_AXIL_REGS -- requirements
Module: demo_axil_regs

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, byte-address width of the AXI4-Lite slave port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, fixed; any other value is an elaboration error.
REQ-003 SHALL have ports, one per line, as follows:
  ACLK  in  1  single clock; all logic on the rising edge
  ARESET  in  1  asynchronous, active-high reset
  S_AXI_AWADDR  in  ADDR_WIDTH  write address
  S_AXI_AWPROT  in  3  ignored
  S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
  S_AXI_WDATA  in  32  write data
  S_AXI_WSTRB  in  4  byte enables
  S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
  S_AXI_BRESP  out  2  write response
  S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake
  S_AXI_ARADDR  in  ADDR_WIDTH  read address
  S_AXI_ARPROT  in  3  ignored
  S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
  S_AXI_RDATA  out  32  read data
  S_AXI_RRESP  out  2  read response
  S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake
  REG_OUT  out  128  slv_reg3..slv_reg0 concatenated, slv_reg0 in bits [31:0]

Function
REQ-004 SHALL implement four 32-bit read/write registers slv_reg0..3 at byte offsets 0x0, 0x4, 0x8, 0xC, decoded from ADDR[ADDR_WIDTH-1:2]; ADDR[1:0] are ignored.
REQ-005 SHALL use a write FSM with states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA and W_RESP.
- AWREADY is 1 in W_IDLE and W_HAVE_DATA.
- WREADY is 1 in W_IDLE and W_HAVE_ADDR.
- Both are 0 in W_RESP.
REQ-006 SHALL handle AW and W arrivals as follows:
- AW and W handshaking in the same cycle in W_IDLE -> W_RESP.
- AW alone -> W_HAVE_ADDR, with the address latched.
- W alone -> W_HAVE_DATA, with data and strobes latched.
- The missing channel handshaking later -> W_RESP.
REQ-007 SHALL commit the write on the clock edge entering W_RESP, updating only the bytes whose WSTRB bit is 1; WSTRB=0 leaves the register unchanged and still returns OKAY.
REQ-008 SHALL hold BVALID=1 in W_RESP until BVALID&BREADY, then return to W_IDLE; minimum AW/W-handshake-to-BVALID latency is 1 cycle.
REQ-009 SHALL use a read FSM with states R_IDLE (ARREADY=1) and R_RESP (RVALID=1).
- On an AR handshake, RDATA and RRESP are registered and the FSM goes to R_RESP.
- RDATA and RRESP are held stable until RVALID&RREADY, then the FSM returns to R_IDLE.
- Read latency is 1 cycle.
REQ-010 SHALL run the read and write FSMs independently. When a read handshake and a write commit target the same register in the same cycle, the read returns the pre-write value.
REQ-011 SHALL, for any offset >= 0x10 that is not enabled by REQ-016, write nothing and give BRESP=SLVERR (2'b10); a read of such an offset gives RDATA=0 and RRESP=SLVERR.
REQ-012 SHALL keep BRESP/RRESP at OKAY (2'b00) for all valid accesses, and drive REG_OUT combinationally from the registers, so REG_OUT changes in the cycle after commit.
REQ-013 SHALL leave all outputs stable while VALID is asserted and READY is deasserted, with no combinational path from any input to any VALID or READY output.

Reset
REQ-014 SHALL, while ARESET=1, force both FSMs to their IDLE states and clear slv_reg0..3, the latched address/data, RDATA, BRESP, RRESP, BVALID and RVALID to 0. AWREADY, WREADY and ARREADY SHALL be 0 during reset and 1 from the first clock edge after deassertion.
REQ-015 SHALL abandon any in-flight transaction on reset assertion mid-operation (including W_HAVE_ADDR or R_RESP), with no register update and no response issued afterwards.

Configuration
REQ-016 SHALL, with macro DEMO_AXIL_WR_COUNT_EN defined, provide a read-only 32-bit register at offset 0x10.
- It counts committed valid writes and wraps 0xFFFFFFFF->0.
- It is cleared by reset.
- Writes to it give SLVERR and leave it unchanged.
REQ-017 SHALL, without DEMO_AXIL_WR_COUNT_EN, make offset 0x10 behave as any other unmapped offset per REQ-011.

Structure
REQ-018 SHALL place the AXI response constants (OKAY, SLVERR), the register offset constants and the write/read FSM state enums in package demo_axil_pkg.
REQ-019 SHALL be a single module with no sub-modules; the byte-strobe merge is a function in demo_axil_pkg.

Verification
REQ-020 SHALL cover the following directed scenarios:
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> each read returns the written value with OKAY; REG_OUT=0x00000004_00000003_00000002_00000001.
- W asserted 3 cycles before AW, writing 0xDEADBEEF to 0x8 -> WREADY handshake first, FSM in W_HAVE_DATA, BVALID 1 cycle after AW, slv_reg2=0xDEADBEEF.
- slv_reg1=0xFFFFFFFF, then write 0x00000000 with WSTRB=4'b0101 -> readback 0xFF00FF00.
- Read of 0x14, and write of 0x20 -> RRESP=SLVERR with RDATA=0; BRESP=SLVERR; registers unchanged.
- BREADY/RREADY held 0 for 5 cycles -> BVALID/RVALID and data stable throughout; no new AW accepted.
- ARESET pulsed while in W_HAVE_ADDR -> no BVALID, registers 0. With DEMO_AXIL_WR_COUNT_EN, 3 writes then a read of 0x10 -> 0x3.

Source files
------------

// File: rtl/demo_axil_pkg.sv
// Shared constants, FSM state encodings and helpers for the demo AXI4-Lite register block.
package demo_axil_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned NUM_REGS = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [7:0] OFF_REG0     = 8'h00;
    localparam logic [7:0] OFF_REG1     = 8'h04;
    localparam logic [7:0] OFF_REG2     = 8'h08;
    localparam logic [7:0] OFF_REG3     = 8'h0C;
    localparam logic [7:0] OFF_WR_COUNT = 8'h10;

    localparam logic [1:0] W_IDLE      = 2'd0;
    localparam logic [1:0] W_HAVE_ADDR = 2'd1;
    localparam logic [1:0] W_HAVE_DATA = 2'd2;
    localparam logic [1:0] W_RESP      = 2'd3;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_val,
                                                     input logic [DATA_W-1:0] new_val,
                                                     input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

    // Word index to {hit, slot} for the read/write registers.
    function automatic logic [2:0] decode_word(input logic [31:0] word);
        case (word)
            32'(OFF_REG0 >> 2): return 3'b100;
            32'(OFF_REG1 >> 2): return 3'b101;
            32'(OFF_REG2 >> 2): return 3'b110;
            32'(OFF_REG3 >> 2): return 3'b111;
            default:            return 3'b000;
        endcase
    endfunction

    function automatic logic is_count_word(input logic [31:0] word);
        return word == 32'(OFF_WR_COUNT >> 2);
    endfunction

endpackage

// File: rtl/demo_axil_regs.sv
// AXI4-Lite slave with four 32-bit R/W registers and independent read/write FSMs.
// Optional read-only write counter at 0x10 when DEMO_AXIL_WR_COUNT_EN is defined.
module demo_axil_regs
    import demo_axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]              S_AXI_AWPROT,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_W-1:0]       S_AXI_WDATA,
    input  logic [STRB_W-1:0]       S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]              S_AXI_ARPROT,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [DATA_W-1:0]       S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic [4*DATA_W-1:0]     REG_OUT
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("demo_axil_regs: DATA_WIDTH must be 32");
        end
        if (ADDR_WIDTH < 5 || ADDR_WIDTH > 34) begin : g_bad_addr_width
            $error("demo_axil_regs: ADDR_WIDTH must be in 5..34");
        end
    endgenerate

    logic [1:0]            r_wstate, w_wstate_nxt;
    logic [0:0]            r_rstate, w_rstate_nxt;
    logic                  r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic                  w_awready_nxt, w_wready_nxt, w_bvalid_nxt, w_arready_nxt, w_rvalid_nxt;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_W-1:0]     r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic [DATA_W-1:0]     r_slv_reg [NUM_REGS];
    logic [1:0]            r_bresp, r_rresp;
    logic [DATA_W-1:0]     r_rdata;
`ifdef DEMO_AXIL_WR_COUNT_EN
    logic [DATA_W-1:0]     r_wr_count;
`endif

    logic                  w_aw_hs, w_w_hs, w_ar_hs;
    logic                  w_commit, w_lat_addr, w_lat_data;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_W-1:0]     w_wr_data;
    logic [STRB_W-1:0]     w_wr_strb;
    logic [31:0]           w_wr_word, w_rd_word;
    logic [2:0]            w_wr_dec, w_rd_dec;
    logic                  w_unused;

    assign w_aw_hs = S_AXI_AWVALID && r_awready;
    assign w_w_hs  = S_AXI_WVALID  && r_wready;
    assign w_ar_hs = S_AXI_ARVALID && r_arready;

    assign w_wr_word = 32'(w_wr_addr[ADDR_WIDTH-1:2]);
    assign w_rd_word = 32'(S_AXI_ARADDR[ADDR_WIDTH-1:2]);
    assign w_wr_dec  = decode_word(w_wr_word);
    assign w_rd_dec  = decode_word(w_rd_word);
    assign w_unused  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], w_wr_addr[1:0]};

    // FSM state and handshake-flag registers; flags stay low while in reset.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_rstate  <= R_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_rstate  <= w_rstate_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
        end
    end

    // Write FSM: collect AW and W in either order, commit on entry to W_RESP.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_commit     = 1'b0;
        w_lat_addr   = 1'b0;
        w_lat_data   = 1'b0;
        w_wr_addr    = S_AXI_AWADDR;
        w_wr_data    = S_AXI_WDATA;
        w_wr_strb    = S_AXI_WSTRB;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wstate_nxt = W_RESP;
                    w_commit     = 1'b1;
                end else if (w_aw_hs) begin
                    w_wstate_nxt = W_HAVE_ADDR;
                    w_lat_addr   = 1'b1;
                end else if (w_w_hs) begin
                    w_wstate_nxt = W_HAVE_DATA;
                    w_lat_data   = 1'b1;
                end
            end
            W_HAVE_ADDR: begin
                w_wr_addr = r_awaddr;
                if (w_w_hs) begin
                    w_wstate_nxt = W_RESP;
                    w_commit     = 1'b1;
                end
            end
            W_HAVE_DATA: begin
                w_wr_data = r_wdata;
                w_wr_strb = r_wstrb;
                if (w_aw_hs) begin
                    w_wstate_nxt = W_RESP;
                    w_commit     = 1'b1;
                end
            end
            W_RESP: begin
                if (r_bvalid && S_AXI_BREADY) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
        w_awready_nxt = (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_DATA);
        w_wready_nxt  = (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_ADDR);
        w_bvalid_nxt  = (w_wstate_nxt == W_RESP);

        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_RESP;
            R_RESP:  if (r_rvalid && S_AXI_RREADY) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
        w_arready_nxt = (w_rstate_nxt == R_IDLE);
        w_rvalid_nxt  = (w_rstate_nxt == R_RESP);
    end

    // Datapath: latches, register file, responses. Reads see pre-commit values.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= RESP_OKAY;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) r_slv_reg[i] <= '0;
`ifdef DEMO_AXIL_WR_COUNT_EN
            r_wr_count <= '0;
`endif
        end else begin
            if (w_lat_addr) r_awaddr <= S_AXI_AWADDR;
            if (w_lat_data) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                if (w_wr_dec[2]) begin
                    r_slv_reg[w_wr_dec[1:0]] <= strb_merge(r_slv_reg[w_wr_dec[1:0]], w_wr_data, w_wr_strb);
                    r_bresp <= RESP_OKAY;
`ifdef DEMO_AXIL_WR_COUNT_EN
                    r_wr_count <= r_wr_count + DATA_W'(1);
`endif
                end else begin
                    r_bresp <= RESP_SLVERR;
                end
            end
            if (w_ar_hs) begin
                if (w_rd_dec[2]) begin
                    r_rdata <= r_slv_reg[w_rd_dec[1:0]];
                    r_rresp <= RESP_OKAY;
`ifdef DEMO_AXIL_WR_COUNT_EN
                end else if (is_count_word(w_rd_word)) begin
                    r_rdata <= r_wr_count;
                    r_rresp <= RESP_OKAY;
`endif
                end else begin
                    r_rdata <= '0;
                    r_rresp <= RESP_SLVERR;
                end
            end
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign REG_OUT       = {r_slv_reg[3], r_slv_reg[2], r_slv_reg[1], r_slv_reg[0]};

endmodule

// File: tb/tb_demo_axil_regs.sv
// Directed self-checking bench for demo_axil_regs (honours DEMO_AXIL_WR_COUNT_EN).
module tb_demo_axil_regs;

    logic         ACLK;
    logic         ARESET;
    logic [5:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [5:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] REG_OUT;

    int n_checks = 0;
    int n_fail   = 0;

    demo_axil_regs #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .REG_OUT       (REG_OUT)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        logic aw_f, w_f;
        S_AXI_AWADDR  = a;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        for (int i = 0; i < 20 && (S_AXI_AWVALID || S_AXI_WVALID); i++) begin
            aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
            w_f  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (aw_f) S_AXI_AWVALID = 1'b0;
            if (w_f)  S_AXI_WVALID  = 1'b0;
        end
        if (S_AXI_AWVALID || S_AXI_WVALID) begin
            chk("wr_handshake_timeout", 1'b0, 1'b1);
            S_AXI_AWVALID = 1'b0;
            S_AXI_WVALID  = 1'b0;
        end
        for (int i = 0; i < 20 && !S_AXI_BVALID; i++) tick();
        if (!S_AXI_BVALID) begin
            chk("bvalid_timeout", 1'b0, 1'b1);
            resp = 2'b11;
        end else begin
            resp = S_AXI_BRESP;
            tick();
        end
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic ar_f;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 20 && S_AXI_ARVALID; i++) begin
            ar_f = S_AXI_ARREADY;
            tick();
            if (ar_f) S_AXI_ARVALID = 1'b0;
        end
        if (S_AXI_ARVALID) begin
            chk("ar_handshake_timeout", 1'b0, 1'b1);
            S_AXI_ARVALID = 1'b0;
        end
        for (int i = 0; i < 20 && !S_AXI_RVALID; i++) tick();
        if (!S_AXI_RVALID) begin
            chk("rvalid_timeout", 1'b0, 1'b1);
            d    = '1;
            resp = 2'b11;
        end else begin
            d    = S_AXI_RDATA;
            resp = S_AXI_RRESP;
            tick();
        end
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic        saw_b;

        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA  = '0; S_AXI_WSTRB  = '0; S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY = 1'b1;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1;
        repeat (2) tick();

        // Reset values
        chk("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        chk("rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        chk("rst_resp_data", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, '0);
        chk("rst_reg_out", REG_OUT, '0);
        ARESET = 1'b0;
        tick();
        chk("post_rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        // Basic write and readback of all four registers
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(i * 4), 32'(i + 1), 4'hF, resp);
            chk("basic_bresp", resp, 2'b00);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(i * 4), rd, resp);
            chk("basic_rdata", rd, 32'(i + 1));
            chk("basic_rresp", resp, 2'b00);
        end
        chk("basic_reg_out", REG_OUT, 128'h00000004_00000003_00000002_00000001);

        // W leads AW by three cycles
        S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wfirst_have_data", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b100);
            if (i < 2) tick();
        end
        S_AXI_AWADDR = 6'h08; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        chk("wfirst_bvalid", {S_AXI_BVALID, S_AXI_BRESP}, 3'b100);
        tick();
        chk("wfirst_bdone", S_AXI_BVALID, 1'b0);
        chk("wfirst_reg2", REG_OUT[95:64], 32'hDEADBEEF);

        // Byte strobes
        axi_write(6'h04, 32'hFFFFFFFF, 4'hF, resp);
        axi_write(6'h04, 32'h00000000, 4'b0101, resp);
        chk("strb_bresp", resp, 2'b00);
        axi_read(6'h04, rd, resp);
        chk("strb_rdata", rd, 32'hFF00FF00);
        axi_write(6'h04, 32'h12345678, 4'b0000, resp);
        chk("strb0_bresp", resp, 2'b00);
        axi_read(6'h04, rd, resp);
        chk("strb0_rdata", rd, 32'hFF00FF00);

        // Unmapped offsets
        axi_read(6'h14, rd, resp);
        chk("unmap_rd", {resp, rd}, {2'b10, 32'h0});
        axi_write(6'h20, 32'hAAAAAAAA, 4'hF, resp);
        chk("unmap_wr_bresp", resp, 2'b10);
        axi_write(6'h10, 32'h5A5A5A5A, 4'hF, resp);
        chk("off10_wr_bresp", resp, 2'b10);
        chk("unmap_reg_out", REG_OUT, 128'h00000004_DEADBEEF_FF00FF00_00000001);
        axi_read(6'h10, rd, resp);
`ifdef DEMO_AXIL_WR_COUNT_EN
        chk("off10_rd", {resp, rd}, {2'b00, 32'd8});
`else
        chk("off10_rd", {resp, rd}, {2'b10, 32'h0});
`endif

        // Write-response backpressure
        S_AXI_BREADY = 1'b0;
        S_AXI_AWADDR = 6'h0C; S_AXI_WDATA = 32'h00000055; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        S_AXI_AWADDR = 6'h00; S_AXI_WDATA = 32'h99;
        for (int i = 0; i < 5; i++) begin
            chk("bstall", {S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY}, 5'b10000);
            tick();
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_BREADY = 1'b1;
        tick();
        chk("bstall_done", S_AXI_BVALID, 1'b0);
        chk("bstall_reg_out", REG_OUT, 128'h00000055_DEADBEEF_FF00FF00_00000001);

        // Read-data backpressure
        S_AXI_RREADY = 1'b0;
        S_AXI_ARADDR = 6'h04; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        S_AXI_ARADDR = 6'h08;
        for (int i = 0; i < 5; i++) begin
            chk("rstall", {S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RRESP, S_AXI_RDATA},
                {1'b1, 1'b0, 2'b00, 32'hFF00FF00});
            tick();
        end
        S_AXI_RREADY = 1'b1;
        tick();
        chk("rstall_done", S_AXI_RVALID, 1'b0);

        // Read and write commit to the same register in the same cycle
        S_AXI_AWADDR = 6'h00; S_AXI_WDATA = 32'h22; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 6'h00;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        chk("collide_rd", {S_AXI_RVALID, S_AXI_BVALID, S_AXI_RDATA}, {2'b11, 32'h1});
        tick();
        chk("collide_reg0", REG_OUT[31:0], 32'h22);

        // Reset asserted while in W_HAVE_ADDR
        S_AXI_AWADDR = 6'h04; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        chk("have_addr", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b01);
        ARESET = 1'b1;
        #3;
        chk("midrst_async", {S_AXI_AWREADY, S_AXI_WREADY, REG_OUT}, '0);
        tick();
        ARESET = 1'b0;
        saw_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            saw_b = saw_b | S_AXI_BVALID;
            tick();
        end
        chk("midrst_no_bvalid", saw_b, 1'b0);
        chk("midrst_reg_out", REG_OUT, '0);

        // Three writes after reset, then read the counter offset
        axi_write(6'h00, 32'hA, 4'hF, resp);
        axi_write(6'h04, 32'hB, 4'hF, resp);
        axi_write(6'h08, 32'hC, 4'hF, resp);
        chk("post_rst_reg_out", REG_OUT, 128'h00000000_0000000C_0000000B_0000000A);
        axi_read(6'h10, rd, resp);
`ifdef DEMO_AXIL_WR_COUNT_EN
        chk("wr_count", {resp, rd}, {2'b00, 32'd3});
`else
        chk("off10_unmapped", {resp, rd}, {2'b10, 32'h0});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
